// File: rtl/me_block_sched.sv
// Block-level sequencer for the me266 motion-estimation engine: fetch/calc control per block,
// with the previous block's SAD/MV result serialised on 1-bit lanes while the next block is fetched.
module me_block_sched #(
    parameter int CUR_WORDS = 16,
    parameter int REF_WORDS = 48,
    parameter int BLOCKS    = 129600,
    parameter int BLK_W     = 17,
    parameter int SAD_W     = 14,
    parameter int MV_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             cur_read,
    output logic             ref_read,
    output logic             calc_en,
    output logic [BLK_W-1:0] blk_idx,
    input  logic             sad_vld,
    input  logic [SAD_W-1:0] sad_in,
    input  logic [MV_W-1:0]  mv_x_in,
    input  logic [MV_W-1:0]  mv_y_in,
    output logic             sign_sad,
    output logic             sad_out,
    output logic             x_out,
    output logic             y_out
);
    typedef enum logic [2:0] {S_IDLE, S_CUR, S_REF, S_CALC, S_HOLD, S_FIN} state_t;

    localparam int MAX_WORDS = (CUR_WORDS > REF_WORDS) ? CUR_WORDS : REF_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);
    localparam int SER_W     = $clog2(SAD_W);

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
    logic [SAD_W-1:0] pend_sad, sad_sr, src_sad;
    logic [MV_W-1:0]  pend_x, pend_y, x_sr, y_sr, src_x, src_y;
    logic             ser_active;
    logic [SER_W-1:0] ser_cnt;
    logic             ser_last, ser_free, load_ser, last_blk;

    assign ser_last = ser_active && (ser_cnt == SER_W'(SAD_W - 1));
    assign ser_free = !ser_active || ser_last;
    assign load_ser = ser_free && ((state == S_CALC && sad_vld) || state == S_HOLD);
    assign last_blk = (blk_idx == BLK_W'(BLOCKS - 1));

    // A result arriving while the serialiser is free bypasses the pending register.
    assign src_sad = (state == S_CALC) ? sad_in  : pend_sad;
    assign src_x   = (state == S_CALC) ? mv_x_in : pend_x;
    assign src_y   = (state == S_CALC) ? mv_y_in : pend_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            blk_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cur_read <= 1'b0;
            ref_read <= 1'b0;
            calc_en  <= 1'b0;
            pend_sad <= '0;
            pend_x   <= '0;
            pend_y   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later assignment to the same
            // register in this block overrides an earlier one, which the load path relies on.
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_CUR;
                    busy     <= 1'b1;
                    cur_read <= 1'b1;
                    word_cnt <= '0;
                end
                S_CUR: if (word_cnt == CNT_W'(CUR_WORDS - 1)) begin
                    state    <= S_REF;
                    cur_read <= 1'b0;
                    ref_read <= 1'b1;
                    word_cnt <= '0;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
                S_REF: if (word_cnt == CNT_W'(REF_WORDS - 1)) begin
                    state    <= S_CALC;
                    ref_read <= 1'b0;
                    calc_en  <= 1'b1;
                    word_cnt <= '0;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
                S_CALC: if (sad_vld) begin
                    calc_en  <= 1'b0;
                    pend_sad <= sad_in;
                    pend_x   <= mv_x_in;
                    pend_y   <= mv_y_in;
                    state    <= S_HOLD;
                end
                S_HOLD: ;
                S_FIN: if (done) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else if (ser_last) begin
                    done    <= 1'b1;
                    blk_idx <= '0;
                end
                default: state <= S_IDLE;
            endcase

            if (load_ser) begin
                if (last_blk) begin
                    state <= S_FIN;
                end else begin
                    state    <= S_CUR;
                    blk_idx  <= blk_idx + 1'b1;
                    cur_read <= 1'b1;
                    word_cnt <= '0;
                end
            end
        end
    end

    // Shift registers fill with zeros, so the lanes read 0 once their bits are spent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ser_active <= 1'b0;
            ser_cnt    <= '0;
            sad_sr     <= '0;
            x_sr       <= '0;
            y_sr       <= '0;
        end else if (load_ser) begin
            ser_active <= 1'b1;
            ser_cnt    <= '0;
            sad_sr     <= src_sad;
            x_sr       <= src_x;
            y_sr       <= src_y;
        end else if (ser_active) begin
            ser_cnt <= ser_cnt + 1'b1;
            sad_sr  <= {sad_sr[SAD_W-2:0], 1'b0};
            x_sr    <= {x_sr[MV_W-2:0], 1'b0};
            y_sr    <= {y_sr[MV_W-2:0], 1'b0};
            if (ser_last) ser_active <= 1'b0;
        end
    end

    assign sign_sad = ser_active;
    assign sad_out  = sad_sr[SAD_W-1];
    assign x_out    = x_sr[MV_W-1];
    assign y_out    = y_sr[MV_W-1];
endmodule

// File: tb/tb_me_block_sched.sv
// Bench for me_block_sched: a per-frame timeline model built from block timing rules,
// compared against the DUT every cycle, plus hand-computed literal expectations.
module tb_me_block_sched;
    localparam int CUR_WORDS = 4;
    localparam int REF_WORDS = 6;
    localparam int BLOCKS    = 2;
    localparam int BLK_W     = 17;
    localparam int SAD_W     = 14;
    localparam int MV_W      = 4;
    localparam int TBL       = 256;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             sad_vld = 1'b0;
    logic [SAD_W-1:0] sad_in = '0;
    logic [MV_W-1:0]  mv_x_in = '0;
    logic [MV_W-1:0]  mv_y_in = '0;
    logic             busy, done, cur_read, ref_read, calc_en;
    logic             sign_sad, sad_out, x_out, y_out;
    logic [BLK_W-1:0] blk_idx;

    me_block_sched #(
        .CUR_WORDS(CUR_WORDS), .REF_WORDS(REF_WORDS), .BLOCKS(BLOCKS),
        .BLK_W(BLK_W), .SAD_W(SAD_W), .MV_W(MV_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cur_read(cur_read), .ref_read(ref_read), .calc_en(calc_en), .blk_idx(blk_idx),
        .sad_vld(sad_vld), .sad_in(sad_in), .mv_x_in(mv_x_in), .mv_y_in(mv_y_in),
        .sign_sad(sign_sad), .sad_out(sad_out), .x_out(x_out), .y_out(y_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             busy, done, cur, rf, calc, sign, sad, x, y;
        logic [BLK_W-1:0] blk;
    } obs_t;

    obs_t             exp_tbl[TBL];
    obs_t             cap_tbl[TBL];
    logic             drv_start[TBL];
    logic             drv_vld[TBL];
    logic [SAD_W-1:0] drv_sad[TBL];
    logic [MV_W-1:0]  drv_x[TBL];
    logic [MV_W-1:0]  drv_y[TBL];
    int               cyc = 0;
    int               frame_len = 0;
    int               checks = 0;
    int               failures = 0;
    bit               checking = 1'b0;
    obs_t             act;

    assign act = {busy, done, cur_read, ref_read, calc_en, sign_sad, sad_out, x_out, y_out, blk_idx};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Output vector order: busy done cur ref calc sign sad x y blk_idx[16:0]
    always @(negedge clk) begin
        if (checking) begin
            cap_tbl[cyc] = act;
            check($sformatf("cycle %0d outputs", cyc), 32'(act), 32'(exp_tbl[cyc]));
        end
    end

    task automatic clear_tables();
        for (int i = 0; i < TBL; i++) begin
            exp_tbl[i]   = '0;
            cap_tbl[i]   = '0;
            drv_start[i] = 1'b0;
            drv_vld[i]   = 1'b0;
            drv_sad[i]   = 14'h2AAA;
            drv_x[i]     = 4'hA;
            drv_y[i]     = 4'h5;
        end
    endtask

    // Timeline of one frame started in cycle 0. lat = cycles from the first calc_en cycle to sad_vld.
    task automatic plan_frame(input int lat0, input logic [SAD_W-1:0] sad0, input logic [MV_W-1:0] x0, y0,
                              input int lat1, input logic [SAD_W-1:0] sad1, input logic [MV_W-1:0] x1, y1,
                              input int stray_start, input int stray_vld);
        int               lats[BLOCKS];
        logic [SAD_W-1:0] sads[BLOCKS];
        logic [MV_W-1:0]  xs[BLOCKS];
        logic [MV_W-1:0]  ys[BLOCKS];
        int               cs[BLOCKS];
        int               t, v, s, prev_s, fin, last;
        lats = '{lat0, lat1};
        sads = '{sad0, sad1};
        xs   = '{x0, x1};
        ys   = '{y0, y1};
        clear_tables();
        drv_start[0] = 1'b1;
        t      = 1;
        prev_s = -SAD_W;
        for (int k = 0; k < BLOCKS; k++) begin
            cs[k] = t;
            for (int i = 0; i < CUR_WORDS; i++) exp_tbl[t+i].cur = 1'b1;
            t += CUR_WORDS;
            for (int i = 0; i < REF_WORDS; i++) exp_tbl[t+i].rf = 1'b1;
            t += REF_WORDS;
            for (int i = 0; i <= lats[k]; i++) exp_tbl[t+i].calc = 1'b1;
            v = t + lats[k];
            drv_vld[v] = 1'b1;
            drv_sad[v] = sads[k];
            drv_x[v]   = xs[k];
            drv_y[v]   = ys[k];
            // Serialisation starts after sad_vld, but never before the previous result is out.
            s = (v + 1 > prev_s + SAD_W) ? v + 1 : prev_s + SAD_W;
            for (int i = 0; i < SAD_W; i++) begin
                exp_tbl[s+i].sign = 1'b1;
                exp_tbl[s+i].sad  = sads[k][SAD_W-1-i];
                if (i < MV_W) begin
                    exp_tbl[s+i].x = xs[k][MV_W-1-i];
                    exp_tbl[s+i].y = ys[k][MV_W-1-i];
                end
            end
            prev_s = s;
            t = s;
        end
        fin = prev_s + SAD_W;
        for (int k = 0; k < BLOCKS; k++) begin
            last = (k < BLOCKS - 1) ? cs[k+1] - 1 : fin - 1;
            for (int c = cs[k]; c <= last; c++) exp_tbl[c].blk = BLK_W'(k);
        end
        for (int c = 1; c <= fin; c++) exp_tbl[c].busy = 1'b1;
        exp_tbl[fin].done = 1'b1;
        if (stray_start >= 0) drv_start[stray_start] = 1'b1;
        if (stray_vld >= 0) drv_vld[stray_vld] = 1'b1;
        frame_len = fin;
    endtask

    task automatic run_frame(input int abort_at);
        for (int n = 0; n <= frame_len; n++) begin
            @(posedge clk);
            #1;
            cyc      = n;
            checking = 1'b1;
            start    = drv_start[n];
            sad_vld  = drv_vld[n];
            sad_in   = drv_sad[n];
            mv_x_in  = drv_x[n];
            mv_y_in  = drv_y[n];
            if (n == abort_at) begin
                checking = 1'b0;
                #2 rst = 1'b0;
                #1 check("async reset clears outputs", 32'(act), 32'd0);
                start   = 1'b0;
                sad_vld = 1'b0;
                return;
            end
        end
        @(negedge clk);
        #1 checking = 1'b0;
        start   = 1'b0;
        sad_vld = 1'b0;
    endtask

    task automatic run_idle(input int n);
        clear_tables();
        frame_len = n - 1;
        run_frame(-1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SAD_W-1:0] sbits;
        logic [MV_W-1:0]  xbits, ybits;
        int               cnt;

        #12 check("reset state outputs", 32'(act), 32'd0);
        #10 rst = 1'b1;

        // Frame 1: block 1 result arrives mid-serialisation, held until block 0 finishes.
        plan_frame(2, 14'd1234, 4'hD, 4'h5, 1, 14'h1F0F, 4'h7, 4'h8, -1, -1);
        check("model frame length", 32'(frame_len), 32'd42);
        check("model serial abut", 32'(exp_tbl[27].sign & exp_tbl[28].sign), 32'd1);
        run_frame(-1);
        for (int i = 0; i < SAD_W; i++) sbits[SAD_W-1-i] = cap_tbl[14+i].sad;
        for (int i = 0; i < MV_W; i++) begin
            xbits[MV_W-1-i] = cap_tbl[14+i].x;
            ybits[MV_W-1-i] = cap_tbl[14+i].y;
        end
        check("F1 sad_out stream", 32'(sbits), 32'(14'b00010011010010));
        check("F1 x_out stream", 32'(xbits), 32'(4'b1101));
        check("F1 y_out stream", 32'(ybits), 32'(4'b0101));
        cnt = 0;
        for (int c = 13; c <= 42; c++) cnt += int'(cap_tbl[c].sign);
        check("F1 sign_sad run length", 32'(cnt), 32'd28);
        check("F1 calc_en first cycle", 32'({cap_tbl[10].rf, cap_tbl[11].calc}), 32'b11);
        check("F1 block 1 cur_read at 14", 32'(cap_tbl[14].cur), 32'd1);
        check("F1 done and busy at 42", 32'({cap_tbl[42].done, cap_tbl[42].busy}), 32'b11);

        // Frame 2 starts the cycle after done; stray start and stray sad_vld ignored.
        plan_frame(20, 14'h2001, 4'h7, 4'h8, 30, 14'h3FFF, 4'h0, 4'hF, 3, 2);
        run_frame(-1);
        cnt = 0;
        for (int c = 0; c <= frame_len; c++) cnt += int'(cap_tbl[c].cur);
        check("F2 cur_read count", 32'(cnt), 32'(BLOCKS * CUR_WORDS));
        check("F2 no early sign_sad", 32'(cap_tbl[3].sign), 32'd0);

        // Frame 3: block 1 sad_vld lands in block 0's last serial cycle.
        plan_frame(0, 14'h0001, 4'h8, 4'h1, 3, 14'h2000, 4'h1, 4'h8, -1, 43);
        run_frame(-1);

        // Frame 4: reset during block 1 REF while block 0 is mid-serialisation.
        plan_frame(2, 14'd1234, 4'hD, 4'h5, 1, 14'h1F0F, 4'h7, 4'h8, -1, -1);
        run_frame(20);
        repeat (2) @(posedge clk);
        #2 check("outputs held at 0 in reset", 32'(act), 32'd0);
        rst = 1'b1;
        run_idle(6);

        // Frame 5: recovery after reset.
        plan_frame(5, 14'h155A, 4'h6, 4'h9, 0, 14'h0ABC, 4'hB, 4'h3, -1, -1);
        run_frame(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/me_block_sched.md
Name: me_block_sched

Overview:
Block-level sequencer for the me266 motion-estimation engine over one 4K frame.
- Per block: drives the current-block fetch strobe, then the reference-window fetch strobe, then enables the SAD calculation.
- Captures the block's best SAD and motion vector, and serialises them on the 1-bit result lanes (sign_sad / sad_out / x_out / y_out).
- Serialisation of block k overlaps the fetch of block k+1.

Parameters:
CUR_WORDS, 16, 32-bit current-block words fetched per block (8x8 block, 8-bit pixels)
REF_WORDS, 48, 64-bit reference-window words fetched per block
BLOCKS, 129600, blocks per frame (3840x2160 / 64)
BLK_W, 17, width of block index
SAD_W, 14, SAD width (signed result lane, MSB first)
MV_W, 4, motion-vector component width (two's complement, range -8..+7)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  frame start request, sampled only in IDLE
busy  out  1  high from the cycle after start is accepted through the done cycle
done  out  1  one-cycle pulse when the last block's result has been fully serialised
cur_read  out  1  current-block word fetch strobe; source presents the next word
ref_read  out  1  reference-window word fetch strobe
calc_en  out  1  enables the SAD datapath for the current block
blk_idx  out  BLK_W  index of the block being fetched/calculated
sad_vld  in  1  datapath result valid, single-cycle pulse
sad_in  in  SAD_W  best SAD of the block
mv_x_in  in  MV_W  best x displacement
mv_y_in  in  MV_W  best y displacement
sign_sad  out  1  high during the SAD_W serial result cycles
sad_out  out  1  serial SAD, bit SAD_W-1 first
x_out  out  1  serial mv_x, MSB first, in serial cycles 0..MV_W-1; 0 afterwards
y_out  out  1  serial mv_y, same timing as x_out

Behaviour:
- Reset (rst low, asynchronous): FSM=IDLE, blk_idx=0, pending flag=0, serialiser idle. All outputs are 0.
- Fetch/calc FSM states: IDLE, CUR, REF, CALC, HOLD, FIN.
- IDLE: start=1 -> CUR at the next edge; busy rises with CUR. start is ignored in every other state.
- CUR: cur_read=1 for exactly CUR_WORDS consecutive cycles, then -> REF with no gap.
- REF: ref_read=1 for exactly REF_WORDS consecutive cycles, then -> CALC with no gap.
- CALC: calc_en=1 until and including the cycle sad_vld=1. There is no timeout. sad_vld outside CALC is ignored.
- On sad_vld in CALC, {sad_in, mv_x_in, mv_y_in} is latched into a pending register.
- Serialiser free (idle, or in its last cycle SAD_W-1 this cycle): pending loads into the shift register next cycle and serial cycle 0 starts. Otherwise -> HOLD.
- HOLD: all strobes 0. Waits until the serialiser is free, then loads pending.
- After loading: if blk_idx == BLOCKS-1 -> FIN; else blk_idx+1 and -> CUR in the same transition.
- FIN: waits until the serialiser finishes the last result. done=1 for the cycle after the final serial bit, then -> IDLE. busy falls with done, and blk_idx returns to 0.
- Serialiser:
  - sign_sad=1 for exactly SAD_W consecutive cycles per block.
  - Cycle i: sad_out = sad bit SAD_W-1-i; x_out/y_out = mv bit MV_W-1-i for i < MV_W, else 0.
  - Back-to-back results may abut with no idle cycle (HOLD release in cycle SAD_W-1).
- cur_read, ref_read and calc_en are mutually exclusive; at most one is high in any cycle.
- rst low mid-frame: everything aborts immediately, including any partial serial word. No done is issued.

Test Plan:
1. CUR_WORDS=4, REF_WORDS=6, BLOCKS=2; start pulse at cycle 0.
   -> cur_read cycles 1-4, ref_read cycles 5-10, calc_en from cycle 11.
2. sad_vld at cycle 13 with sad=14'sd1234, mv=(-3,+5).
   -> sign_sad cycles 14-27; sad_out = 00010011010010; x_out = 1101 then 0; y_out = 0101 then 0; cur_read for block 1 from cycle 14.
3. Block 1 sad_vld while block 0 still serialising.
   -> FSM in HOLD; block 1 serialisation starts in the cycle immediately after block 0's last bit; sign_sad stays high for 28 consecutive cycles.
4. Last block (BLOCKS=2) finishes serialising.
   -> done=1 for one cycle after its last bit; busy falls in that same cycle; blk_idx=0; a new start is accepted the next cycle.
5. rst low during REF of block 1 (or mid-serialisation).
   -> all outputs 0 asynchronously; after release, idle until start; no done pulse.
6. start asserted while busy, and sad_vld pulsed during CUR.
   -> both ignored; strobe counts unchanged; no spurious sign_sad.
